// File: rtl/serv_pkg.sv
// Shared types and constants for the serv bus scheduler and its helpers.
package serv_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  localparam logic [WB_SEL_W-1:0] WB_SEL_DEFAULT = 4'hf;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
  } wb_req_t;

endpackage

// File: rtl/serv_watchdog.sv
// Saturating cycle watchdog: clears on i_clr, counts while i_en, flags all-ones.
module serv_watchdog #(
  parameter int unsigned W = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign o_expired = &cnt_q;

  // Saturates at all-ones so an expired count can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && !o_expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serv_bus_sched.sv
// Shares one Wishbone master between ibus and dbus, one grant at a time,
// with a watchdog that force-completes transactions a dead slave never acks.
module serv_bus_sched
  import serv_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8,
  parameter bit          DBUS_PRIO = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [WB_ADR_W-1:0] i_ibus_adr,
  input  logic                i_ibus_cyc,
  output logic [WB_DAT_W-1:0] o_ibus_rdt,
  output logic                o_ibus_ack,
  input  logic [WB_ADR_W-1:0] i_dbus_adr,
  input  logic [WB_DAT_W-1:0] i_dbus_dat,
  input  logic [WB_SEL_W-1:0] i_dbus_sel,
  input  logic                i_dbus_we,
  input  logic                i_dbus_cyc,
  output logic [WB_DAT_W-1:0] o_dbus_rdt,
  output logic                o_dbus_ack,
  output logic [WB_ADR_W-1:0] o_wb_adr,
  output logic [WB_DAT_W-1:0] o_wb_dat,
  output logic [WB_SEL_W-1:0] o_wb_sel,
  output logic                o_wb_we,
  output logic                o_wb_cyc,
  input  logic [WB_DAT_W-1:0] i_wb_rdt,
  input  logic                i_wb_ack,
  output logic                o_timeout,
  output logic                o_timeout_seen
);

  sched_state_e state_q;
  sched_state_e state_d;
  logic         seen_q;
  logic         seen_d;
  logic         gnt_i;
  logic         gnt_d;
  logic         wd_expired;
  logic         force_done;
  logic         done;
  wb_req_t      req;

  assign gnt_i = (state_q == ST_GNT_I);
  assign gnt_d = (state_q == ST_GNT_D);

  serv_watchdog #(
    .W (TIMEOUT_W)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (state_q == ST_IDLE),
    .i_en      (!i_wb_ack),
    .o_expired (wd_expired)
  );

  // Cycle is gated by the granted requester's cyc so an abort drops it at once.
  assign o_wb_cyc   = (gnt_i && i_ibus_cyc) || (gnt_d && i_dbus_cyc);
  assign force_done = o_wb_cyc && wd_expired && !i_wb_ack;
  assign done       = o_wb_cyc && (i_wb_ack || force_done);

  assign o_timeout      = force_done;
  assign o_timeout_seen = seen_q;
  assign seen_d         = seen_q || force_done;

  assign o_ibus_ack = gnt_i && done;
  assign o_dbus_ack = gnt_d && done;
  assign o_ibus_rdt = (gnt_i && !force_done) ? i_wb_rdt : '0;
  assign o_dbus_rdt = (gnt_d && !force_done) ? i_wb_rdt : '0;

  always_comb begin
    req = '{adr: i_ibus_adr, dat: '0, sel: WB_SEL_DEFAULT, we: 1'b0};
    if (gnt_d) begin
      req = '{adr: i_dbus_adr, dat: i_dbus_dat, sel: i_dbus_sel, we: i_dbus_we};
    end
  end

  assign o_wb_adr = req.adr;
  assign o_wb_dat = req.dat;
  assign o_wb_sel = req.sel;
  assign o_wb_we  = req.we;

  // Every grant returns to IDLE, which guarantees one idle cycle between grants.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_dbus_cyc && i_ibus_cyc) begin
          state_d = DBUS_PRIO ? ST_GNT_D : ST_GNT_I;
        end else if (i_dbus_cyc) begin
          state_d = ST_GNT_D;
        end else if (i_ibus_cyc) begin
          state_d = ST_GNT_I;
        end
      end
      ST_GNT_I: begin
        if (i_wb_ack || wd_expired || !i_ibus_cyc) state_d = ST_IDLE;
      end
      ST_GNT_D: begin
        if (i_wb_ack || wd_expired || !i_dbus_cyc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
    end
  end

endmodule

// File: tb/tb_serv_bus_sched.sv
// Directed bench for serv_bus_sched with a 3-bit watchdog and dbus priority.
module tb_serv_bus_sched;

  logic        clk;
  logic        rst_n;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        timeout;
  logic        timeout_seen;

  int total = 0;
  int bad   = 0;

  serv_bus_sched #(
    .TIMEOUT_W (3),
    .DBUS_PRIO (1'b1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_ibus_adr     (ibus_adr),
    .i_ibus_cyc     (ibus_cyc),
    .o_ibus_rdt     (ibus_rdt),
    .o_ibus_ack     (ibus_ack),
    .i_dbus_adr     (dbus_adr),
    .i_dbus_dat     (dbus_dat),
    .i_dbus_sel     (dbus_sel),
    .i_dbus_we      (dbus_we),
    .i_dbus_cyc     (dbus_cyc),
    .o_dbus_rdt     (dbus_rdt),
    .o_dbus_ack     (dbus_ack),
    .o_wb_adr       (wb_adr),
    .o_wb_dat       (wb_dat),
    .o_wb_sel       (wb_sel),
    .o_wb_we        (wb_we),
    .o_wb_cyc       (wb_cyc),
    .i_wb_rdt       (wb_rdt),
    .i_wb_ack       (wb_ack),
    .o_timeout      (timeout),
    .o_timeout_seen (timeout_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    wb_rdt   = '0; wb_ack   = 1'b0;

    @(posedge clk); #3;
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_iack", 32'(ibus_ack), 32'd0);
    chk("rst_dack", 32'(dbus_ack), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    chk("rst_seen", 32'(timeout_seen), 32'd0);
    chk("rst_irdt", ibus_rdt, 32'd0);
    chk("rst_drdt", dbus_rdt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch, slave acks in cycle 3
    next_cyc();
    ibus_cyc = 1'b1; ibus_adr = 32'h100;
    #2 chk("f_c0_cyc", 32'(wb_cyc), 32'd0);
    next_cyc(); #2 chk("f_c1_cyc", 32'(wb_cyc), 32'd1);
    chk("f_c1_adr", wb_adr, 32'h100);
    chk("f_c1_ack", 32'(ibus_ack), 32'd0);
    next_cyc(); #2 chk("f_c2_cyc", 32'(wb_cyc), 32'd1);
    next_cyc();
    wb_ack = 1'b1; wb_rdt = 32'h0000_0013;
    #2 chk("f_c3_cyc", 32'(wb_cyc), 32'd1);
    chk("f_c3_ack", 32'(ibus_ack), 32'd1);
    chk("f_c3_rdt", ibus_rdt, 32'h13);
    chk("f_c3_dack", 32'(dbus_ack), 32'd0);
    chk("f_c3_drdt", dbus_rdt, 32'd0);
    next_cyc();
    wb_ack = 1'b0; wb_rdt = '0; ibus_cyc = 1'b0;
    #2 chk("f_c4_cyc", 32'(wb_cyc), 32'd0);
    chk("f_c4_ack", 32'(ibus_ack), 32'd0);

    // Simultaneous request: dbus first, ibus two cycles after the dbus ack
    next_cyc();
    ibus_cyc = 1'b1; ibus_adr = 32'h104;
    dbus_cyc = 1'b1; dbus_adr = 32'h200; dbus_dat = 32'hDEAD_BEEF;
    dbus_sel = 4'b0011; dbus_we = 1'b1;
    #2 chk("s_c0_cyc", 32'(wb_cyc), 32'd0);
    next_cyc();
    wb_ack = 1'b1;
    #2 chk("s_c1_cyc", 32'(wb_cyc), 32'd1);
    chk("s_c1_adr", wb_adr, 32'h200);
    chk("s_c1_dat", wb_dat, 32'hDEAD_BEEF);
    chk("s_c1_sel", 32'(wb_sel), 32'h3);
    chk("s_c1_we", 32'(wb_we), 32'd1);
    chk("s_c1_dack", 32'(dbus_ack), 32'd1);
    chk("s_c1_iack", 32'(ibus_ack), 32'd0);
    next_cyc();
    wb_ack = 1'b0; dbus_cyc = 1'b0; dbus_we = 1'b0;
    #2 chk("s_c2_cyc", 32'(wb_cyc), 32'd0);
    next_cyc();
    wb_ack = 1'b1; wb_rdt = 32'h0000_0093;
    #2 chk("s_c3_cyc", 32'(wb_cyc), 32'd1);
    chk("s_c3_adr", wb_adr, 32'h104);
    chk("s_c3_we", 32'(wb_we), 32'd0);
    chk("s_c3_sel", 32'(wb_sel), 32'hf);
    chk("s_c3_dat", wb_dat, 32'd0);
    chk("s_c3_iack", 32'(ibus_ack), 32'd1);
    chk("s_c3_irdt", ibus_rdt, 32'h93);
    chk("s_c3_drdt", dbus_rdt, 32'd0);
    next_cyc();
    wb_ack = 1'b0; wb_rdt = '0; ibus_cyc = 1'b0;

    // Timeout: no ack, forced ack 7 cycles after cyc rises
    next_cyc();
    ibus_cyc = 1'b1; ibus_adr = 32'h300; wb_rdt = 32'hAAAA_AAAA;
    for (int c = 1; c <= 7; c++) begin
      next_cyc();
      #2 chk($sformatf("t_c%0d_ack", c), 32'(ibus_ack), 32'd0);
      chk($sformatf("t_c%0d_to", c), 32'(timeout), 32'd0);
      chk($sformatf("t_c%0d_cyc", c), 32'(wb_cyc), 32'd1);
    end
    next_cyc();
    #2 chk("t_c8_ack", 32'(ibus_ack), 32'd1);
    chk("t_c8_rdt", ibus_rdt, 32'd0);
    chk("t_c8_to", 32'(timeout), 32'd1);
    chk("t_c8_seen", 32'(timeout_seen), 32'd0);
    next_cyc();
    ibus_cyc = 1'b0; wb_rdt = '0;
    #2 chk("t_c9_to", 32'(timeout), 32'd0);
    chk("t_c9_seen", 32'(timeout_seen), 32'd1);
    chk("t_c9_cyc", 32'(wb_cyc), 32'd0);

    // Ack coinciding with expiry: the slave ack wins
    next_cyc();
    dbus_cyc = 1'b1; dbus_adr = 32'h400; dbus_we = 1'b0; dbus_sel = 4'hf;
    for (int c = 1; c <= 6; c++) begin
      next_cyc();
    end
    next_cyc();
    #2 chk("x_c7_dack", 32'(dbus_ack), 32'd0);
    next_cyc();
    wb_ack = 1'b1; wb_rdt = 32'h55;
    #2 chk("x_c8_dack", 32'(dbus_ack), 32'd1);
    chk("x_c8_rdt", dbus_rdt, 32'h55);
    chk("x_c8_to", 32'(timeout), 32'd0);
    next_cyc();
    wb_ack = 1'b0; wb_rdt = '0; dbus_cyc = 1'b0;
    #2 chk("x_c9_seen", 32'(timeout_seen), 32'd1);

    // Abort: dbus drops cyc in its second grant cycle, pending ibus follows
    next_cyc();
    dbus_cyc = 1'b1; dbus_adr = 32'h500; ibus_cyc = 1'b1; ibus_adr = 32'h108;
    next_cyc();
    #2 chk("a_c1_cyc", 32'(wb_cyc), 32'd1);
    chk("a_c1_adr", wb_adr, 32'h500);
    next_cyc();
    dbus_cyc = 1'b0;
    #2 chk("a_c2_cyc", 32'(wb_cyc), 32'd0);
    chk("a_c2_dack", 32'(dbus_ack), 32'd0);
    chk("a_c2_iack", 32'(ibus_ack), 32'd0);
    next_cyc();
    #2 chk("a_c3_cyc", 32'(wb_cyc), 32'd0);
    next_cyc();
    #2 chk("a_c4_cyc", 32'(wb_cyc), 32'd1);
    chk("a_c4_adr", wb_adr, 32'h108);
    wb_ack = 1'b1;
    #1 chk("a_c4_iack", 32'(ibus_ack), 32'd1);
    next_cyc();
    wb_ack = 1'b0; ibus_cyc = 1'b0;

    // Reset asserted mid-grant
    next_cyc();
    dbus_cyc = 1'b1; dbus_adr = 32'h600;
    next_cyc();
    #2 chk("r_c1_cyc", 32'(wb_cyc), 32'd1);
    rst_n = 1'b0;
    #1 chk("r_async_cyc", 32'(wb_cyc), 32'd0);
    chk("r_async_dack", 32'(dbus_ack), 32'd0);
    chk("r_async_seen", 32'(timeout_seen), 32'd0);
    dbus_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    #2 chk("r_post_cyc", 32'(wb_cyc), 32'd0);
    chk("r_post_seen", 32'(timeout_seen), 32'd0);
    ibus_cyc = 1'b1; ibus_adr = 32'h10c;
    next_cyc();
    #2 chk("r_post_gnt", 32'(wb_cyc), 32'd1);
    chk("r_post_adr", wb_adr, 32'h10c);
    ibus_cyc = 1'b0;
    next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serv_bus_sched.md
# serv_bus_sched

Scheduler that shares one Wishbone master port between the core's instruction-fetch bus (ibus) and data bus (dbus). It sits between the bit-serial core and the memory/peripheral interconnect. It grants one requester at a time, holds the grant until the transaction finishes, and forces completion with a timeout if a slave never acknowledges, so the core cannot deadlock on a dead address.

## Interface
- TIMEOUT_W, default 8: width of the per-transaction watchdog counter. A transaction times out after 2^TIMEOUT_W-1 cycles.
- DBUS_PRIO, default 1: when 1, dbus wins a simultaneous request from IDLE; when 0, ibus wins.

- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_ibus_adr  in  32  fetch address
- i_ibus_cyc  in  1  fetch request, held until ack
- o_ibus_rdt  out  32  fetch data
- o_ibus_ack  out  1  fetch complete, 1-cycle strobe
- i_dbus_adr  in  32  data address
- i_dbus_dat  in  32  write data
- i_dbus_sel  in  4  byte enables
- i_dbus_we  in  1  write enable
- i_dbus_cyc  in  1  data request, held until ack
- o_dbus_rdt  out  32  read data
- o_dbus_ack  out  1  data complete, 1-cycle strobe
- o_wb_adr / o_wb_dat / o_wb_sel / o_wb_we  out  32/32/4/1  shared master request
- o_wb_cyc  out  1  shared master strobe (cyc=stb)
- i_wb_rdt  in  32  slave read data
- i_wb_ack  in  1  slave acknowledge
- o_timeout  out  1  1-cycle pulse when a transaction is force-completed
- o_timeout_seen  out  1  sticky flag; cleared only by reset

## Operation
- There are three states: IDLE, GNT_I and GNT_D.
- IDLE:
  - If i_dbus_cyc & i_ibus_cyc, go to GNT_D when DBUS_PRIO=1, else GNT_I.
  - Otherwise go to whichever single request is present.
  - With no request, stay in IDLE.
- GNT_x:
  - o_wb_cyc=1. The o_wb_* request fields are driven from requester x. Unused fields come from ibus: o_wb_we=0, o_wb_sel=4'hf, o_wb_dat=0.
  - i_wb_ack is routed combinationally to x's ack. i_wb_rdt is routed to x's rdt.
  - The other requester sees ack=0 and rdt=0.
- Exit from GNT_x to IDLE happens on any of:
  - (a) i_wb_ack;
  - (b) watchdog expiry: x's ack is forced to 1, rdt=0, o_timeout=1, o_timeout_seen set;
  - (c) abort: x deasserts cyc without an ack. No ack is issued and o_wb_cyc drops in the same cycle (combinationally gated by x's cyc).
- Every grant passes through IDLE for at least one cycle. There are no back-to-back grants, so the requester's cyc drop after ack is always observed.
- Watchdog:
  - Counter is cleared in IDLE and increments each GNT cycle without i_wb_ack.
  - Expiry means counter == all-ones and i_wb_ack=0.
  - If i_wb_ack and expiry coincide, the ack wins: o_timeout=0 and rdt comes from the slave.
  - The counter never wraps.
- In IDLE, o_wb_cyc=0 and both acks are 0. Request fields follow the ibus mux; their value is don't-care.

## Timing
- Reset values (asynchronous on i_rst_n low): state IDLE, watchdog 0, o_timeout_seen 0. This gives o_wb_cyc=0, o_ibus_ack=0, o_dbus_ack=0, o_timeout=0, and o_ibus_rdt=o_dbus_rdt=0.
- Release of reset is synchronous to i_clk. The first possible grant is the first edge after deassertion.
- Latency: request cyc rises in cycle N → o_wb_cyc=1 in N+1. Ack in cycle M → requester ack in M (zero added latency) → IDLE in M+1.
- A zero-wait slave gives a minimum of 2 cycles per transaction and 1 idle cycle between transactions.
- Timeout: with no ack, the forced ack occurs in the cycle where the watchdog = 2^TIMEOUT_W-1, which is 2^TIMEOUT_W-1 cycles after o_wb_cyc rises.
- Reset asserted mid-grant: o_wb_cyc drops asynchronously and no ack is produced. The slave must tolerate an abandoned cycle.
- The sticky flag updates on the clock edge after the o_timeout pulse.

## Structure
- State encoding (IDLE/GNT_I/GNT_D, 2 bits) and the default o_wb_sel value go in the shared package serv_pkg.
- The watchdog is a natural sub-module: serv_watchdog (ports i_clk, i_rst_n, i_clr, i_en, o_expired; parameter W). It is reusable for the CSR timer path.
- Arbitration FSM and muxes stay in the top module.

## Test plan
- Single fetch: ibus_cyc=1 at cycle 0, adr=0x100, slave acks in cycle 3 with 0x00000013.
  - o_wb_cyc goes 1 in cycles 1–3 and 0 in cycle 4.
  - o_ibus_ack=1 only in cycle 3, with o_ibus_rdt=0x13.
- Simultaneous request: both cyc=1 with DBUS_PRIO=1 and dbus writing 0xDEADBEEF, sel=4'b0011.
  - dbus is granted first with o_wb_we=1 and o_wb_sel=0011.
  - After the ack, ibus is granted exactly 2 cycles later.
- Timeout: TIMEOUT_W=3 and the slave never acks.
  - Forced ack arrives 7 cycles after o_wb_cyc rises, with rdt=0.
  - o_timeout pulses once and o_timeout_seen stays 1 afterward.
- Ack at expiry: TIMEOUT_W=3 and the slave acks on cycle 7 with 0x55.
  - rdt=0x55 and o_timeout=0.
- Abort: dbus drops cyc during cycle 2 of its grant.
  - o_wb_cyc=0 that same cycle and no ack is issued.
  - FSM returns to IDLE and serves a pending ibus next.
- Reset mid-grant: pull i_rst_n low during GNT_D.
  - o_wb_cyc=0 with no clock edge needed.
  - After release, the FSM is IDLE with o_timeout_seen=0.
